lc2k_control: RTL and testbench

Multicycle control unit for the LC2K CPU. Sequences each instruction through fetch, decode, execute, memory and write-back. It drives the 3-bit register-file read/write indices and `CONTROL_ENABLE_REG_WRITE` into the register file, plus the ALU, PC and memory-select lines of the datapath. It sits between the instruction/data memory port and the register file, and is the only agent that writes the register file.

---
 rtl/lc2k_pkg.sv | 51 +++++
 rtl/lc2k_decode.sv | 33 +++
 rtl/lc2k_control.sv | 212 +++++++++++++++++++++
 tb/tb_lc2k_control.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lc2k_pkg.sv
// Shared LC2K definitions: opcodes, control FSM states, IR field positions and
// datapath select encodings used by the control unit, datapath and register file.
package lc2k_pkg;

    typedef enum logic [2:0] {
        OpAdd  = 3'd0,
        OpNor  = 3'd1,
        OpLw   = 3'd2,
        OpSw   = 3'd3,
        OpBeq  = 3'd4,
        OpJalr = 3'd5,
        OpHalt = 3'd6,
        OpNoop = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalt
    } state_e;

    localparam int unsigned RegIdxW   = 3;
    localparam int unsigned OpcodeLsb = 22;
    localparam int unsigned RegALsb   = 19;
    localparam int unsigned RegBLsb   = 16;
    localparam int unsigned DestLsb   = 0;
    localparam int unsigned OffsetLsb = 0;
    localparam int unsigned OffsetW   = 16;

    localparam logic [1:0] WbSelAlu   = 2'd0;
    localparam logic [1:0] WbSelMem   = 2'd1;
    localparam logic [1:0] WbSelPcInc = 2'd2;

    localparam logic [1:0] PcSelInc    = 2'd0;
    localparam logic [1:0] PcSelBranch = 2'd1;
    localparam logic [1:0] PcSelRegA   = 2'd2;

    localparam logic MemAddrPc  = 1'b0;
    localparam logic MemAddrAlu = 1'b1;

    localparam logic AluAdd = 1'b0;
    localparam logic AluNor = 1'b1;

    localparam logic AluBReg = 1'b0;
    localparam logic AluBImm = 1'b1;

endpackage

// File: rtl/lc2k_decode.sv
// Combinational instruction-register decode: register fields, opcode and the
// opcode classes the control FSM branches on.
module lc2k_decode
    import lc2k_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0]  ir,
    output opcode_e            opcode,
    output logic [RegIdxW-1:0] reg_a,
    output logic [RegIdxW-1:0] reg_b,
    output logic [RegIdxW-1:0] dest_reg,
    output logic               is_rtype,
    output logic               is_mem,
    output logic               is_sw,
    output logic               writes_reg
);

    // Offset bits feed the datapath directly; the control unit never looks at them.
    logic unused_ir;
    assign unused_ir = ^{ir[DATA_W-1:OpcodeLsb+3], ir[RegBLsb-1:RegIdxW]};

    assign opcode   = opcode_e'(ir[OpcodeLsb +: 3]);
    assign reg_a    = ir[RegALsb +: RegIdxW];
    assign reg_b    = ir[RegBLsb +: RegIdxW];
    assign dest_reg = ir[DestLsb +: RegIdxW];

    assign is_rtype   = (opcode == OpAdd) || (opcode == OpNor);
    assign is_mem     = (opcode == OpLw) || (opcode == OpSw);
    assign is_sw      = (opcode == OpSw);
    assign writes_reg = is_rtype || (opcode == OpLw) || (opcode == OpJalr);

endmodule

// File: rtl/lc2k_control.sv
// Multicycle LC2K control unit: fetch/decode/execute/memory/write-back FSM,
// instruction register and retired-instruction counter.
module lc2k_control
    import lc2k_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] instr,
    input  logic              mem_ack,
    input  logic              alu_eq,
    output logic              mem_req,
    output logic              mem_we,
    output logic              mem_addr_sel,
    output logic [2:0]        read_regA,
    output logic [2:0]        read_regB,
    output logic [2:0]        write_reg,
    output logic              CONTROL_ENABLE_REG_WRITE,
    output logic [1:0]        wb_sel,
    output logic              alu_op,
    output logic              alu_b_sel,
    output logic              pc_we,
    output logic [1:0]        pc_sel,
    output logic              halted,
    output logic [DATA_W-1:0] instr_count
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] count_q;
    logic              ir_load;
    logic              retire;
    logic              reg_write;

    opcode_e           opcode;
    logic [RegIdxW-1:0] reg_a, reg_b, dest_reg;
    logic              is_rtype, is_mem, is_sw, writes_reg;

    lc2k_decode #(
        .DATA_W (DATA_W)
    ) u_decode (
        .ir         (ir_q),
        .opcode     (opcode),
        .reg_a      (reg_a),
        .reg_b      (reg_b),
        .dest_reg   (dest_reg),
        .is_rtype   (is_rtype),
        .is_mem     (is_mem),
        .is_sw      (is_sw),
        .writes_reg (writes_reg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_load = 1'b0;
        retire  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StFetch;
            end
            StFetch: begin
                if (mem_ack) begin
                    ir_load = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (opcode == OpHalt) begin
                    state_d = StHalt;
                    retire  = 1'b1;
                end else if (opcode == OpNoop) begin
                    state_d = StFetch;
                    retire  = 1'b1;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                if (is_rtype) begin
                    state_d = StWb;
                end else if (is_mem) begin
                    state_d = StMem;
                end else begin
                    // beq and jalr complete here
                    state_d = StFetch;
                    retire  = 1'b1;
                end
            end
            StMem: begin
                if (mem_ack) begin
                    if (is_sw) begin
                        state_d = StFetch;
                        retire  = 1'b1;
                    end else begin
                        state_d = StWb;
                    end
                end
            end
            StWb: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = MemAddrPc;
        read_regA    = reg_a;
        read_regB    = reg_b;
        write_reg    = '0;
        reg_write    = 1'b0;
        wb_sel       = WbSelAlu;
        alu_op       = AluAdd;
        alu_b_sel    = AluBReg;
        pc_we        = 1'b0;
        pc_sel       = PcSelInc;
        halted       = 1'b0;
        unique case (state_q)
            StFetch: begin
                mem_req      = 1'b1;
                mem_addr_sel = MemAddrPc;
            end
            StDecode: begin
                if (opcode == OpNoop) begin
                    pc_we  = 1'b1;
                    pc_sel = PcSelInc;
                end
            end
            StExec: begin
                if (opcode == OpNor) alu_op = AluNor;
                if (is_mem) alu_b_sel = AluBImm;
                if (opcode == OpBeq) begin
                    pc_we  = 1'b1;
                    pc_sel = alu_eq ? PcSelBranch : PcSelInc;
                end
                if (opcode == OpJalr) begin
                    // Link register is written with PC+1 while the PC jumps to regA.
                    pc_we     = 1'b1;
                    pc_sel    = PcSelRegA;
                    write_reg = reg_b;
                    wb_sel    = WbSelPcInc;
                    reg_write = 1'b1;
                end
            end
            StMem: begin
                mem_req      = 1'b1;
                mem_addr_sel = MemAddrAlu;
                mem_we       = is_sw;
                alu_b_sel    = AluBImm;
                pc_we        = is_sw && mem_ack;
            end
            StWb: begin
                reg_write = writes_reg;
                pc_we     = 1'b1;
                pc_sel    = PcSelInc;
                if (is_rtype) begin
                    write_reg = dest_reg;
                    wb_sel    = WbSelAlu;
                    alu_op    = (opcode == OpNor) ? AluNor : AluAdd;
                end else begin
                    write_reg = reg_b;
                    wb_sel    = WbSelMem;
                end
            end
            StHalt: begin
                halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // r0 is hardwired: the strobe is dropped but the instruction still retires.
    assign CONTROL_ENABLE_REG_WRITE = reg_write && (write_reg != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q <= '0;
        end else if (ir_load) begin
            ir_q <= instr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (retire) begin
            count_q <= count_q + DATA_W'(1);
        end
    end

    assign instr_count = count_q;

endmodule

// File: tb/tb_lc2k_control.sv
// Directed self-checking bench for lc2k_control: per-instruction cycle snapshots
// compared against hand-derived control values.
module tb_lc2k_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] instr;
    logic        mem_ack;
    logic        alu_eq;
    logic        mem_req, mem_we, mem_addr_sel;
    logic [2:0]  read_regA, read_regB, write_reg;
    logic        CONTROL_ENABLE_REG_WRITE;
    logic [1:0]  wb_sel;
    logic        alu_op, alu_b_sel, pc_we;
    logic [1:0]  pc_sel;
    logic        halted;
    logic [31:0] instr_count;

    typedef struct packed {
        logic       req;
        logic       we;
        logic       addr_sel;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [2:0] wr;
        logic       strobe;
        logic [1:0] wb;
        logic       aop;
        logic       bsel;
        logic       pcwe;
        logic [1:0] pcsel;
        logic       hlt;
    } obs_t;

    obs_t snap [1:16];
    int   n_cmp = 0;
    int   n_err = 0;
    int   nstrobe;

    lc2k_control #(
        .DATA_W (32)
    ) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .start                    (start),
        .instr                    (instr),
        .mem_ack                  (mem_ack),
        .alu_eq                   (alu_eq),
        .mem_req                  (mem_req),
        .mem_we                   (mem_we),
        .mem_addr_sel             (mem_addr_sel),
        .read_regA                (read_regA),
        .read_regB                (read_regB),
        .write_reg                (write_reg),
        .CONTROL_ENABLE_REG_WRITE (CONTROL_ENABLE_REG_WRITE),
        .wb_sel                   (wb_sel),
        .alu_op                   (alu_op),
        .alu_b_sel                (alu_b_sel),
        .pc_we                    (pc_we),
        .pc_sel                   (pc_sel),
        .halted                   (halted),
        .instr_count              (instr_count)
    );

    always #5 clk = ~clk;

    function automatic obs_t outs();
        return {mem_req, mem_we, mem_addr_sel, read_regA, read_regB, write_reg,
                CONTROL_ENABLE_REG_WRITE, wb_sel, alu_op, alu_b_sel, pc_we, pc_sel, halted};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs n cycles starting in FETCH, acking memory in cycles a1 and a2.
    task automatic run(input logic [31:0] w, input int a1, input int a2, input int n);
        nstrobe = 0;
        for (int c = 1; c <= n; c++) begin
            instr   = w;
            mem_ack = (c == a1) || (c == a2);
            #1;
            snap[c] = outs();
            if (snap[c].strobe) nstrobe++;
            @(posedge clk);
            #1;
        end
        mem_ack = 1'b0;
    endtask

    task automatic chk_fetch(input string tag);
        #1;
        chk(tag, 32'({mem_req, mem_addr_sel}), 32'b10);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        instr   = '0;
        mem_ack = 1'b0;
        alu_eq  = 1'b0;
        #3;
        chk("reset_outs", 32'(outs()), 32'd0);
        chk("reset_count", instr_count, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("idle_no_req", 32'(mem_req), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;

        // add r1,r1 -> r3
        run(32'h0009_0003, 1, 0, 4);
        chk("add_fetch_req", 32'(snap[1].req), 32'd1);
        chk("add_dec_ra", 32'(snap[2].ra), 32'd1);
        chk("add_dec_rb", 32'(snap[2].rb), 32'd1);
        chk("add_dec_noreq", 32'(snap[2].req), 32'd0);
        chk("add_exec_nostrobe", 32'(snap[3].strobe), 32'd0);
        chk("add_wb_strobe", 32'(snap[4].strobe), 32'd1);
        chk("add_wb_wr", 32'(snap[4].wr), 32'd3);
        chk("add_wb_sel", 32'(snap[4].wb), 32'd0);
        chk("add_wb_pcwe", 32'(snap[4].pcwe), 32'd1);
        chk("add_nstrobe", 32'(nstrobe), 32'd1);
        chk("add_count", instr_count, 32'd1);
        chk_fetch("add_next_fetch");

        // lw r1,r1,5 with two wait cycles on both accesses
        run(32'h0089_0005, 3, 8, 9);
        chk("lw_wait_req", 32'(snap[2].req), 32'd1);
        chk("lw_mem_req", 32'(snap[6].req), 32'd1);
        chk("lw_mem_addr", 32'(snap[6].addr_sel), 32'd1);
        chk("lw_mem_we", 32'(snap[6].we), 32'd0);
        chk("lw_mem_bsel", 32'(snap[6].bsel), 32'd1);
        chk("lw_exec_bsel", 32'(snap[5].bsel), 32'd1);
        chk("lw_wb_strobe", 32'(snap[9].strobe), 32'd1);
        chk("lw_wb_wr", 32'(snap[9].wr), 32'd1);
        chk("lw_wb_sel", 32'(snap[9].wb), 32'd1);
        chk("lw_nstrobe", 32'(nstrobe), 32'd1);
        chk("lw_count", instr_count, 32'd2);
        chk_fetch("lw_next_fetch");

        // beq r1,r2 taken then not taken
        alu_eq = 1'b1;
        run(32'h010A_0002, 1, 0, 3);
        chk("beq_eq_pcwe", 32'(snap[3].pcwe), 32'd1);
        chk("beq_eq_pcsel", 32'(snap[3].pcsel), 32'd1);
        chk("beq_eq_nostrobe", 32'(nstrobe), 32'd0);
        chk_fetch("beq_eq_next_fetch");
        alu_eq = 1'b0;
        run(32'h010A_0002, 1, 0, 3);
        chk("beq_ne_pcwe", 32'(snap[3].pcwe), 32'd1);
        chk("beq_ne_pcsel", 32'(snap[3].pcsel), 32'd0);
        chk("beq_ne_nostrobe", 32'(nstrobe), 32'd0);
        chk("beq_count", instr_count, 32'd4);
        chk_fetch("beq_ne_next_fetch");

        // add r1,r1 -> r0: retires without a write strobe
        run(32'h0009_0000, 1, 0, 4);
        chk("r0_nostrobe", 32'(nstrobe), 32'd0);
        chk("r0_wb_pcwe", 32'(snap[4].pcwe), 32'd1);
        chk("r0_count", instr_count, 32'd5);

        // jalr r2,r3
        run(32'h0153_0000, 1, 0, 3);
        chk("jalr_strobe", 32'(snap[3].strobe), 32'd1);
        chk("jalr_wr", 32'(snap[3].wr), 32'd3);
        chk("jalr_wb_sel", 32'(snap[3].wb), 32'd2);
        chk("jalr_pcsel", 32'(snap[3].pcsel), 32'd2);
        chk("jalr_pcwe", 32'(snap[3].pcwe), 32'd1);
        chk("jalr_count", instr_count, 32'd6);
        chk_fetch("jalr_next_fetch");

        // noop: two cycles
        run(32'h01C0_0000, 1, 0, 2);
        chk("noop_pcwe", 32'(snap[2].pcwe), 32'd1);
        chk("noop_pcsel", 32'(snap[2].pcsel), 32'd0);
        chk("noop_count", instr_count, 32'd7);
        chk_fetch("noop_next_fetch");

        // sw r1,r1,4 zero wait: four cycles
        run(32'h00C9_0004, 1, 4, 4);
        chk("sw_mem_we", 32'(snap[4].we), 32'd1);
        chk("sw_mem_pcwe", 32'(snap[4].pcwe), 32'd1);
        chk("sw_nostrobe", 32'(nstrobe), 32'd0);
        chk("sw_count", instr_count, 32'd8);
        chk_fetch("sw_next_fetch");

        // halt, then start pulses are ignored
        run(32'h0180_0000, 1, 0, 2);
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_count", instr_count, 32'd9);
        for (int i = 0; i < 3; i++) begin
            start   = 1'b1;
            mem_ack = 1'b1;
            step();
            start   = 1'b0;
            mem_ack = 1'b0;
            step();
        end
        chk("halt_sticky", 32'(halted), 32'd1);
        chk("halt_noreq", 32'(mem_req), 32'd0);
        chk("halt_count_hold", instr_count, 32'd9);

        // reset asserted in WB of an add
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        run(32'h0009_0003, 1, 0, 3);
        #1;
        chk("wb_pre_reset_strobe", 32'(CONTROL_ENABLE_REG_WRITE), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("wb_reset_outs", 32'(outs()), 32'd0);
        chk("wb_reset_count", instr_count, 32'd0);
        step();
        chk("reset_hold_outs", 32'(outs()), 32'd0);
        rst_n = 1'b1;
        step();
        chk("idle_after_release", 32'(outs()), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_fetch", 32'(mem_req), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
